// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, read-FSM state type and bit-reverse helper for the FFT output reorder buffer.
// Companion to fft_out_reorder; optional drop accounting is enabled with FFT_REORDER_ERR_EN.
package fft_pkg;

    localparam int BW_DEF    = 16;
    localparam int LOG2N_DEF = 6;
    localparam int N         = 2 ** LOG2N_DEF;
    localparam int NPAIR     = N / 2;
    localparam int CW_DEF    = 2 * BW_DEF;
    localparam int MAX_LOG2N = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } rd_state_t;

    // Reverses the low nbits bits of v; bits above nbits come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                     input int nbits);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < nbits) begin
                r[i] = v[nbits-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Stream interface between the FFT core, the reorder buffer and the downstream sink.
// Drop-accounting signals exist only when FFT_REORDER_ERR_EN is defined.
interface fft_out_reorder_if #(
    parameter int BW    = 16,
    parameter int LOG2N = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    inReal0;
    logic [BW-1:0]    inImag0;
    logic [BW-1:0]    inReal1;
    logic [BW-1:0]    inImag1;

    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    outReal;
    logic [BW-1:0]    outImag;
    logic [LOG2N-1:0] out_index;
    logic             out_last;
`ifdef FFT_REORDER_ERR_EN
    logic             drop_err;
    logic [7:0]       drop_cnt;
`endif

    modport slave (
        input  in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
        output in_ready, out_valid, outReal, outImag, out_index, out_last
`ifdef FFT_REORDER_ERR_EN
        , output drop_err, drop_cnt
`endif
    );

    modport master (
        output in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
        input  in_ready, out_valid, outReal, outImag, out_index, out_last
`ifdef FFT_REORDER_ERR_EN
        , input drop_err, drop_cnt
`endif
    );

endinterface

// File: rtl/fft_out_reorder_bank.sv
// One reorder bank: two write ports (one per pair sample) and a registered read port
// whose output register doubles as the sample output register.
module reorder_bank #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we,
    input  logic [AW-1:0] waddr0,
    input  logic [DW-1:0] wdata0,
    input  logic [AW-1:0] waddr1,
    input  logic [DW-1:0] wdata1,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Both samples of a pair always land on distinct addresses, so no write collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr0] <= wdata0;
            mem[waddr1] <= wdata1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: captures bit-reversed FFT pairs and replays frames in natural order.
// Define FFT_REORDER_ERR_EN to add sticky drop_err and saturating drop_cnt outputs.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic           clk,
    input  logic           nrst,
    fft_out_reorder_if.slave bus
);

    localparam int NN = 2 ** LOG2N;
    localparam int CW = 2 * BW;
    localparam int PW = LOG2N - 1;

    logic [PW-1:0]    pair_cnt_reg;
    logic             wr_bank_reg;
    logic [1:0]       full_reg;
    logic [1:0]       full_next;

    rd_state_t        state_reg;
    logic             rd_bank_reg;
    logic             out_sel_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic [LOG2N-1:0] out_index_reg;

    logic             wr_fire;
    logic             pair_last;
    logic             rd_fire;
    logic             index_last;
    logic             frame_done;
    logic             rd_en;
    logic [LOG2N-1:0] wr_addr0;
    logic [LOG2N-1:0] wr_addr1;
    logic [LOG2N-1:0] rd_addr;
    logic [CW-1:0]    wr_data0;
    logic [CW-1:0]    wr_data1;
    logic [CW-1:0]    rd_data [2];

    // ---------------- write side ----------------
    assign bus.in_ready = !full_reg[wr_bank_reg];
    assign wr_fire      = bus.in_valid && !full_reg[wr_bank_reg];
    assign pair_last    = &pair_cnt_reg;
    assign wr_addr0     = LOG2N'(bitrev(MAX_LOG2N'({pair_cnt_reg, 1'b0}), LOG2N));
    assign wr_addr1     = LOG2N'(bitrev(MAX_LOG2N'({pair_cnt_reg, 1'b1}), LOG2N));
    assign wr_data0     = {bus.inReal0, bus.inImag0};
    assign wr_data1     = {bus.inReal1, bus.inImag1};

    // ---------------- read side ----------------
    assign rd_fire    = (state_reg == STREAM) && out_valid_reg && bus.out_ready;
    assign index_last = &out_index_reg;
    assign frame_done = rd_fire && index_last;
    assign rd_en      = (state_reg == LOAD) || (rd_fire && !index_last);
    assign rd_addr    = (state_reg == LOAD) ? '0 : out_index_reg + 1'b1;

    // Set and clear always target different banks, so both may happen on one edge.
    always_comb begin
        full_next = full_reg;
        if (wr_fire && pair_last) begin
            full_next[wr_bank_reg] = 1'b1;
        end
        if (frame_done) begin
            full_next[rd_bank_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pair_cnt_reg <= '0;
            wr_bank_reg  <= 1'b0;
            full_reg     <= '0;
        end else begin
            full_reg <= full_next;
            if (wr_fire) begin
                if (pair_last) begin
                    pair_cnt_reg <= '0;
                    wr_bank_reg  <= ~wr_bank_reg;
                end else begin
                    pair_cnt_reg <= pair_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= IDLE;
            rd_bank_reg   <= 1'b0;
            out_sel_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_index_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (full_reg[rd_bank_reg]) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    out_sel_reg   <= rd_bank_reg;
                    out_valid_reg <= 1'b1;
                    out_index_reg <= '0;
                    out_last_reg  <= 1'b0;
                    state_reg     <= STREAM;
                end
                STREAM: begin
                    if (rd_fire) begin
                        if (!index_last) begin
                            out_index_reg <= out_index_reg + 1'b1;
                            out_last_reg  <= (out_index_reg == LOG2N'(NN - 2));
                        end else begin
                            rd_bank_reg   <= ~rd_bank_reg;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            state_reg     <= full_reg[~rd_bank_reg] ? LOAD : IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ---------------- bank storage ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic bank_we;
            logic bank_re;
            assign bank_we = wr_fire && (wr_bank_reg == 1'(gi));
            assign bank_re = rd_en && (rd_bank_reg == 1'(gi));

            reorder_bank #(
                .DW (CW),
                .AW (LOG2N)
            ) u_bank (
                .clk    (clk),
                .nrst   (nrst),
                .we     (bank_we),
                .waddr0 (wr_addr0),
                .wdata0 (wr_data0),
                .waddr1 (wr_addr1),
                .wdata1 (wr_data1),
                .re     (bank_re),
                .raddr  (rd_addr),
                .rdata  (rd_data[gi])
            );
        end
    endgenerate

    // Each bank's read register holds the last sample it presented; out_sel picks the live one.
    assign {bus.outReal, bus.outImag} = rd_data[out_sel_reg];
    assign bus.out_valid = out_valid_reg;
    assign bus.out_index = out_index_reg;
    assign bus.out_last  = out_last_reg;

`ifdef FFT_REORDER_ERR_EN
    logic       drop_err_reg;
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_err_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (bus.in_valid && full_reg[wr_bank_reg]) begin
            drop_err_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.drop_err = drop_err_reg;
    assign bus.drop_cnt = drop_cnt_reg;
`endif

endmodule
